// File: rtl/fifo_32_1024_fwft_pkg.sv
// Shared constants and types for the 32x1026 first-word-fall-through FIFO.
//   FIFO_DATA_W       - data width
//   FIFO_ADDR_W       - BRAM address width (depth 2^FIFO_ADDR_W)
//   FIFO_OUTBUF_DEPTH - entries in the output skid buffer
package fifo_32_1024_fwft_pkg;

  localparam int unsigned FIFO_DATA_W       = 32;
  localparam int unsigned FIFO_ADDR_W       = 10;
  localparam int unsigned FIFO_OUTBUF_DEPTH = 2;

  // Output buffer occupancy, 0..FIFO_OUTBUF_DEPTH.
  typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/bram_32_1024_sd.sv
// Simple dual-port BRAM: one synchronous write port, one synchronous read port with
// a 1-cycle read latency. Same-address read/write in one cycle is undefined.
// Ports:
//   clk    - clock
//   resetn - synchronous active-low reset of the read data register only
//   wen    - write enable, waddr/wdata - write address/data
//   rden   - read enable, raddr - read address
//   doutb  - read data, valid the cycle after rden
module bram_32_1024_sd #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rden,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] doutb
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      doutb <= '0;
    end else if (rden) begin
      doutb <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_32_1024_fwft.sv
// First-word-fall-through FIFO: 1024-entry BRAM plus a 2-entry output buffer,
// 1026 entries total. Hides the BRAM read latency behind a valid/ready stream.
// Ports:
//   clk, reset (sync, active-high), flush (sync clear, BRAM contents kept)
//   in_valid/in_ready/in_data    - write side
//   out_valid/out_ready/out_data - read side, out_data is the head entry
//   level                        - entries held (BRAM + in-flight read + buffer)
module fifo_32_1024_fwft
  import fifo_32_1024_fwft_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] MemFull = (ADDR_W+1)'(2**ADDR_W);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count;
  logic              rd_pending_q, rd_pending_d;
  buf_cnt_t          buf_count_q, buf_count_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic              push, pop, issue;
  logic [2:0]        buf_claim;

  logic              bram_wen;
  logic [ADDR_W-1:0] bram_waddr;
  logic              bram_rden;
  logic [ADDR_W-1:0] bram_raddr;
  logic [DATA_W-1:0] bram_doutb;

  assign mem_count = wr_ptr_q - rd_ptr_q;

  assign in_ready  = (mem_count != MemFull) & ~flush & ~reset;
  assign out_valid = (buf_count_q != '0);
  assign out_data  = buf0_q;
  assign level     = mem_count + (ADDR_W+1)'(rd_pending_q) + (ADDR_W+1)'(buf_count_q);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~flush & ~reset;

  // Buffer slots that will be occupied once the in-flight read lands and this
  // cycle's pop is taken; a new read is only issued if it is guaranteed a slot.
  assign buf_claim = {1'b0, buf_count_q} + {2'b0, rd_pending_q} - {2'b0, pop};
  assign issue     = (mem_count != '0) & (buf_claim < 3'(FIFO_OUTBUF_DEPTH)) & ~flush & ~reset;

  assign bram_wen   = push;
  assign bram_waddr = wr_ptr_q[ADDR_W-1:0];
  assign bram_rden  = issue;
  assign bram_raddr = rd_ptr_q[ADDR_W-1:0];

  always_comb begin
    wr_ptr_d     = wr_ptr_q + (ADDR_W+1)'(push);
    rd_ptr_d     = rd_ptr_q + (ADDR_W+1)'(issue);
    rd_pending_d = issue;
    buf_count_d  = buf_count_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;

    if (flush) begin
      // Any read still in flight is discarded by clearing rd_pending.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      buf_count_d = '0;
    end else begin
      case ({rd_pending_q, pop})
        2'b10: begin
          if (buf_count_q == '0) begin
            buf0_d = bram_doutb;
          end else begin
            buf1_d = bram_doutb;
          end
          buf_count_d = buf_count_q + 2'd1;
        end
        2'b01: begin
          buf0_d      = buf1_q;
          buf_count_d = buf_count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; whichever entry is next in order becomes head.
          if (buf_count_q == 2'd2) begin
            buf0_d = buf1_q;
            buf1_d = bram_doutb;
          end else begin
            buf0_d = bram_doutb;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
      buf_count_q  <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pending_q <= rd_pending_d;
      buf_count_q  <= buf_count_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  bram_32_1024_sd #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk    (clk),
    .resetn (~reset),
    .wen    (bram_wen),
    .waddr  (bram_waddr),
    .wdata  (in_data),
    .rden   (bram_rden),
    .raddr  (bram_raddr),
    .doutb  (bram_doutb)
  );

endmodule

// File: tb/tb_fifo_32_1024_fwft.sv
module tb_fifo_32_1024_fwft;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [10:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_32_1024_fwft dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  // Reference model: contents as queues, one in-flight read slot.
  logic [31:0] m_mem[$];
  logic [31:0] m_buf[$];
  bit          m_infl;
  logic [31:0] m_infl_d;

  // Values sampled in the most recent cycle (before its clock edge).
  logic        s_ir, s_ov;
  logic [31:0] s_data;
  int          s_level;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mem.delete();
    m_buf.delete();
    m_infl = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic cycle(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
    bit m_ir, m_ov, m_push, m_pop, m_issue;
    int m_level;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #2;
    s_ir = in_ready; s_ov = out_valid; s_data = out_data; s_level = int'(level);
    m_ir    = (m_mem.size() != 1024) && !fl;
    m_ov    = (m_buf.size() != 0);
    m_level = m_mem.size() + int'(m_infl) + m_buf.size();
    chk("in_ready", 32'(in_ready), 32'(m_ir));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("level", 32'(level), 32'(m_level));
    if (m_ov) chk("out_data", out_data, m_buf[0]);
    if (dut.bram_wen && dut.bram_rden)
      chk("raddr!=waddr", 32'(dut.bram_raddr != dut.bram_waddr), 32'd1);
    m_push  = iv && m_ir;
    m_pop   = m_ov && ordy && !fl;
    m_issue = (m_mem.size() != 0) && ((m_buf.size() + int'(m_infl) - int'(m_pop)) < 2) && !fl;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (m_pop) void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back(m_infl_d);
      m_infl = m_issue;
      if (m_issue) m_infl_d = m_mem.pop_front();
      if (m_push) m_mem.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_0000; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (check) begin
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst wen", 32'(dut.bram_wen), 32'd0);
        chk("rst rden", 32'(dut.bram_rden), 32'd0);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    #1;
    if (check) begin
      chk("post-rst level", 32'(level), 32'd0);
      chk("post-rst out_valid", 32'(out_valid), 32'd0);
      chk("post-rst in_ready", 32'(in_ready), 32'd1);
      chk("post-rst out_data", out_data, 32'd0);
    end
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    bit          fl;
    bit          e_ir;
    bit          e_ov;
    logic [31:0] e_data;
    int          e_level;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int accepts, pops, duty_in, duty_out;

    do_reset(1'b1);

    // Single word latency, then flush with a read in flight, a push and a pop.
    vecs.push_back('{1, 32'hDEADBEEF, 1, 0, 1, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 1, 0, 1, 0, 32'h0, 1});
    vecs.push_back('{0, 32'h0, 1, 0, 1, 0, 32'h0, 1});
    vecs.push_back('{0, 32'h0, 1, 0, 1, 1, 32'hDEADBEEF, 1});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 0, 32'h0, 0});
    vecs.push_back('{1, 32'hA, 0, 0, 1, 0, 32'h0, 0});
    vecs.push_back('{1, 32'hB, 0, 0, 1, 0, 32'h0, 1});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 0, 32'h0, 2});
    vecs.push_back('{1, 32'h1, 1, 1, 0, 1, 32'hA, 2});
    vecs.push_back('{1, 32'h5, 0, 0, 1, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 0, 32'h0, 1});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 0, 32'h0, 1});
    vecs.push_back('{0, 32'h0, 1, 0, 1, 1, 32'h5, 1});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 0, 32'h0, 0});
    foreach (vecs[i]) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d in_ready", i), 32'(s_ir), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d out_valid", i), 32'(s_ov), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d level", i), 32'(s_level), 32'(vecs[i].e_level));
      if (vecs[i].e_ov) chk($sformatf("vec%0d out_data", i), s_data, vecs[i].e_data);
    end

    // Fill to 1026 with no pops, then drain in order.
    do_reset(1'b0);
    accepts = 0;
    for (int c = 0; c < 1200 && accepts < 1026; c++) begin
      cycle(1'b1, 32'(accepts), 1'b0, 1'b0);
      if (s_ir) accepts++;
    end
    chk("fill accepts", 32'(accepts), 32'd1026);
    for (int c = 0; c < 4; c++) cycle(1'b1, 32'hBAD0_0000, 1'b0, 1'b0);
    chk("full in_ready", 32'(s_ir), 32'd0);
    chk("full level", 32'(s_level), 32'd1026);
    for (int i = 0; i < 1026; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain out_valid", 32'(s_ov), 32'd1);
      chk("drain order", s_data, 32'(i));
      if (i == 1) chk("full recovery in_ready", 32'(s_ir), 32'd1);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained level", 32'(s_level), 32'd0);

    // Streaming 3000 words: no bubbles after priming, pointers wrap.
    do_reset(1'b0);
    pops = 0;
    for (int c = 0; c < 3004; c++) begin
      cycle(c < 3000, 32'(c), 1'b1, 1'b0);
      if (c >= 3 && c < 3003) chk("stream out_valid", 32'(s_ov), 32'd1);
      if (s_ov) begin
        chk("stream order", s_data, 32'(pops));
        pops++;
      end
    end
    chk("stream pops", 32'(pops), 32'd3000);

    // Random traffic with occasional flushes.
    do_reset(1'b0);
    duty_in = 50; duty_out = 50;
    for (int c = 0; c < 20000; c++) begin
      if (c % 1000 == 0) begin
        duty_in  = 30 + int'($urandom_range(60));
        duty_out = 30 + int'($urandom_range(60));
      end
      cycle($urandom_range(99) < duty_in, $urandom, $urandom_range(99) < duty_out,
            $urandom_range(999) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
